// File: rtl/gather_packet_arbiter.sv
// Round-robin packet-boundary arbiter in front of a shared gather buffer.
// Forwards one packet at a time, truncates long packets, drops orphan beats.
module gather_packet_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_LEN   = 256,
    parameter int MIN_GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]   in_valid,
    input  logic [NUM_PORTS-1:0]   in_sop,
    input  logic [NUM_PORTS-1:0]   in_eop,
    output logic [NUM_PORTS-1:0]   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [15:0]            drop_count
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    // With no gap required the packet end returns straight to arbitration.
    localparam logic [1:0] S_END  = (MIN_GAP == 0) ? S_IDLE : S_GAP;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [7:0]           od_q, od_d;
    logic                 ov_q, ov_d;
    logic                 osop_q, osop_d;
    logic                 oeop_q, oeop_d;
    logic [15:0]          drop_q;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] drop_v;
    logic                 found;
    logic [IW-1:0]        sel;
    logic [IW:0]          cand;
    logic [3:0]           pop;
    logic [16:0]          drop_sum;
    logic [7:0]           g_data;
    logic                 g_sop;
    logic                 g_eop;
    logic                 g_acc;

    assign req    = in_valid & in_sop;
    assign g_data = in_data[8*gidx_q +: 8];
    assign g_sop  = in_sop[gidx_q];
    assign g_eop  = in_eop[gidx_q];
    assign g_acc  = (state_q == S_PASS) && in_valid[gidx_q]
                    && in_ready[gidx_q];

    // Pick the first requesting port after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, rr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_PORTS))
                cand = cand - (IW+1)'(NUM_PORTS);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IW-1:0];
            end
        end
    end

    // Per-port accept and drop decisions.
    always_comb begin
        in_ready = '0;
        drop_v   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state_q != S_DISC && !grant_q[i]
                && in_valid[i] && !in_sop[i]) begin
                in_ready[i] = 1'b1;
                drop_v[i]   = 1'b1;
            end
        end
        if (state_q == S_PASS)
            in_ready[gidx_q] = !ov_q || out_ready;
        if (state_q == S_DISC) begin
            in_ready[gidx_q] = 1'b1;
            drop_v[gidx_q]   = in_valid[gidx_q];
        end
    end

    // Number of beats dropped this cycle, and the saturating total.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            pop = pop + {3'b000, drop_v[i]};
    end

    assign drop_sum = {1'b0, drop_q} + {13'b0, pop};

    // Packet FSM, round-robin pointer and output beat register.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        od_d    = od_q;
        ov_d    = ov_q;
        osop_d  = osop_q;
        oeop_d  = oeop_q;
        if (out_ready) begin
            ov_d   = 1'b0;
            osop_d = 1'b0;
            oeop_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gidx_d  = sel;
                    grant_d = NUM_PORTS'(1) << sel;
                    cnt_d   = '0;
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                if (g_acc) begin
                    od_d   = g_data;
                    ov_d   = 1'b1;
                    osop_d = g_sop;
                    oeop_d = g_eop;
                    cnt_d  = cnt_q + CW'(1);
                    if (g_eop) begin
                        rr_d    = gidx_q;
                        grant_d = '0;
                        gap_d   = '0;
                        state_d = S_END;
                    end else if (cnt_q == CW'(MAX_LEN-1)) begin
                        oeop_d  = 1'b1;
                        state_d = S_DISC;
                    end
                end
            end
            S_DISC: begin
                if (in_valid[gidx_q] && in_eop[gidx_q]) begin
                    rr_d    = gidx_q;
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = S_END;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(MIN_GAP-1))
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= IW'(NUM_PORTS-1);
            gidx_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign out_data   = od_q;
    assign out_valid  = ov_q;
    assign out_sop    = osop_q;
    assign out_eop    = oeop_q;
    assign grant      = grant_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_gather_packet_arbiter.sv
// Bench for gather_packet_arbiter: directed scenarios then randomized
// multi-port traffic against a packet-level round-robin reference.
module tb_gather_packet_arbiter;
    localparam int NP  = 4;
    localparam int GAP = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       orph;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [8*NP-1:0] in_data;
    logic [NP-1:0] in_valid;
    logic [NP-1:0] in_sop;
    logic [NP-1:0] in_eop;
    logic [NP-1:0] in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          out_ready;
    logic [NP-1:0] grant;
    logic [15:0]   drop_count;

    gather_packet_arbiter #(
        .NUM_PORTS(NP),
        .MAX_LEN  (256),
        .MIN_GAP  (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_ready (out_ready),
        .grant     (grant),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    logic bubbles;

    beat_t pq[NP][$];
    beat_t expb[NP][$];
    beat_t oq[$];
    beat_t exps[$];
    logic [NP-1:0] lg_grant[$];
    logic [NP-1:0] lg_req[$];
    logic [NP-1:0] lg_rdy[$];
    logic          lg_ov[$];
    logic [7:0]    lg_od[$];
    logic [NP-1:0] seg_q[$];
    int            zr_q[$];
    int            segk_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic s,
                                 input logic e, input logic o);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        b.orph = o;
        return b;
    endfunction

    function automatic int rr_pick(input int last, input logic [NP-1:0] r);
        for (int k = 1; k <= NP; k++)
            if (r[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    task automatic drive();
        beat_t b;
        for (int p = 0; p < NP; p++) begin
            b = '0;
            if (pq[p].size() > 0) b = pq[p][0];
            in_valid[p] = (pq[p].size() > 0) &&
                          (b.sop || b.orph || !bubbles ||
                           ($urandom_range(0, 3) != 0));
            in_sop[p] = b.sop;
            in_eop[p] = b.eop;
            in_data[8*p +: 8] = b.data;
        end
    endtask

    task automatic step();
        logic [NP-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        lg_grant.push_back(grant);
        lg_req.push_back(in_valid & in_sop);
        lg_rdy.push_back(in_ready);
        lg_ov.push_back(out_valid);
        lg_od.push_back(out_data);
        if (out_valid && out_ready)
            oq.push_back(mk(out_data, out_sop, out_eop, 1'b0));
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++)
            if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        drive();
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        lg_grant.delete();
        lg_req.delete();
        lg_rdy.delete();
        lg_ov.delete();
        lg_od.delete();
        oq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < NP; p++) pq[p].delete();
        drive();
        sync();
        sync();
        rst = 1'b0;
    endtask

    task automatic segs();
        int z;
        z = 0;
        seg_q.delete();
        zr_q.delete();
        segk_q.delete();
        for (int k = 0; k < lg_grant.size(); k++) begin
            if (lg_grant[k] == '0) z++;
            else if (k == 0 || lg_grant[k-1] == '0) begin
                seg_q.push_back(lg_grant[k]);
                zr_q.push_back(z);
                segk_q.push_back(k);
                z = 0;
            end
        end
    endtask

    initial begin
        int tot;
        int norph;
        int last;
        int e;
        int neop;
        beat_t b;

        n_tests = 0;
        n_fail  = 0;
        bubbles = 1'b0;
        rst = 1'b1;
        in_valid = '0;
        in_sop = '0;
        in_eop = '0;
        in_data = '0;
        out_ready = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_sop", 32'(out_sop), 32'(0));
        chk("rst_out_eop", 32'(out_eop), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_drop", 32'(drop_count), 32'(0));
        sync();

        // Port 1 three-byte packet
        clr_logs();
        pq[1].push_back(mk(8'hA1, 1'b1, 1'b0, 1'b0));
        pq[1].push_back(mk(8'hA2, 1'b0, 1'b0, 1'b0));
        pq[1].push_back(mk(8'hA3, 1'b0, 1'b1, 1'b0));
        drive();
        repeat (8) step();
        chk("t1_arb_grant", 32'(lg_grant[0]), 32'(0));
        chk("t1_grant", 32'(lg_grant[1]), 32'(4'b0010));
        chk("t1_no_early_out", 32'(lg_ov[1]), 32'(0));
        chk("t1_valid", 32'(lg_ov[2]), 32'(1));
        chk("t1_b0", 32'(lg_od[2]), 32'(8'hA1));
        chk("t1_b1", 32'(lg_od[3]), 32'(8'hA2));
        chk("t1_b2", 32'(lg_od[4]), 32'(8'hA3));
        chk("t1_grant_off", 32'(lg_grant[4]), 32'(0));
        chk("t1_count", 32'(oq.size()), 32'(3));
        if (oq.size() == 3) begin
            chk("t1_first", 32'(oq[0]), 32'(mk(8'hA1, 1'b1, 1'b0, 1'b0)));
            chk("t1_mid", 32'(oq[1]), 32'(mk(8'hA2, 1'b0, 1'b0, 1'b0)));
            chk("t1_last", 32'(oq[2]), 32'(mk(8'hA3, 1'b0, 1'b1, 1'b0)));
        end

        // Ports 0 and 2 contend twice
        do_reset();
        clr_logs();
        for (int r = 0; r < 2; r++) begin
            pq[0].push_back(mk(8'hB0 + 8'(2*r), 1'b1, 1'b0, 1'b0));
            pq[0].push_back(mk(8'hB1 + 8'(2*r), 1'b0, 1'b1, 1'b0));
            pq[2].push_back(mk(8'hC0 + 8'(2*r), 1'b1, 1'b0, 1'b0));
            pq[2].push_back(mk(8'hC1 + 8'(2*r), 1'b0, 1'b1, 1'b0));
        end
        drive();
        repeat (40) step();
        segs();
        chk("t2_nseg", 32'(seg_q.size()), 32'(4));
        if (seg_q.size() == 4) begin
            chk("t2_seg0", 32'(seg_q[0]), 32'(4'b0001));
            chk("t2_seg1", 32'(seg_q[1]), 32'(4'b0100));
            chk("t2_seg2", 32'(seg_q[2]), 32'(4'b0001));
            chk("t2_seg3", 32'(seg_q[3]), 32'(4'b0100));
            chk("t2_gap", 32'(zr_q[1]), 32'(GAP + 1));
        end
        chk("t2_beats", 32'(oq.size()), 32'(8));
        if (oq.size() == 8) begin
            chk("t2_d1", 32'(oq[1].data), 32'(8'hB1));
            chk("t2_d2", 32'(oq[2].data), 32'(8'hC0));
            chk("t2_d4", 32'(oq[4].data), 32'(8'hB2));
            chk("t2_d7", 32'(oq[7].data), 32'(8'hC3));
        end

        // Port 3 five-beat packet with a 3-cycle stall
        clr_logs();
        for (int i = 0; i < 5; i++)
            pq[3].push_back(mk(8'hD0 + 8'(i), i == 0, i == 4, 1'b0));
        drive();
        for (int k = 0; k < 25; k++) begin
            out_ready = !(k >= 4 && k <= 6);
            step();
        end
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            chk("t3_stall_ready", 32'(lg_rdy[k][3]), 32'(0));
            chk("t3_hold_data", 32'(lg_od[k]), 32'(8'hD2));
            chk("t3_hold_valid", 32'(lg_ov[k]), 32'(1));
        end
        chk("t3_count", 32'(oq.size()), 32'(5));
        if (oq.size() == 5)
            for (int i = 0; i < 5; i++)
                chk("t3_beat", 32'(oq[i]),
                    32'(mk(8'hD0 + 8'(i), i == 0, i == 4, 1'b0)));

        // Port 0 260-beat packet is truncated at 256
        do_reset();
        clr_logs();
        for (int i = 0; i < 260; i++)
            pq[0].push_back(mk(8'(i), i == 0, i == 259, 1'b0));
        drive();
        repeat (300) step();
        neop = 0;
        foreach (oq[i]) if (oq[i].eop) neop++;
        chk("t4_count", 32'(oq.size()), 32'(256));
        chk("t4_neop", 32'(neop), 32'(1));
        chk("t4_drop", 32'(drop_count), 32'(4));
        chk("t4_consumed", 32'(pq[0].size()), 32'(0));
        chk("t4_grant_end", 32'(grant), 32'(0));
        if (oq.size() == 256) begin
            chk("t4_sop", 32'(oq[0].sop), 32'(1));
            chk("t4_mid", 32'(oq[100].data), 32'(8'd100));
            chk("t4_pre_last", 32'(oq[254].eop), 32'(0));
            chk("t4_last", 32'(oq[255]), 32'(mk(8'hFF, 1'b0, 1'b1, 1'b0)));
        end

        // Port 2 orphans while port 1 is granted
        clr_logs();
        for (int i = 0; i < 4; i++)
            pq[1].push_back(mk(8'hE0 + 8'(i), i == 0, i == 3, 1'b0));
        drive();
        step();
        step();
        pq[2].push_back(mk(8'h55, 1'b0, 1'b0, 1'b1));
        pq[2].push_back(mk(8'h66, 1'b0, 1'b0, 1'b1));
        drive();
        repeat (10) step();
        chk("t5_granted", 32'(lg_grant[2]), 32'(4'b0010));
        chk("t5_orph_rdy0", 32'(lg_rdy[2][2]), 32'(1));
        chk("t5_orph_rdy1", 32'(lg_rdy[3][2]), 32'(1));
        chk("t5_orph_gone", 32'(pq[2].size()), 32'(0));
        chk("t5_drop", 32'(drop_count), 32'(6));
        chk("t5_count", 32'(oq.size()), 32'(4));
        if (oq.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t5_beat", 32'(oq[i]),
                    32'(mk(8'hE0 + 8'(i), i == 0, i == 3, 1'b0)));

        // Reset in the middle of a packet
        do_reset();
        clr_logs();
        for (int i = 0; i < 4; i++)
            pq[0].push_back(mk(8'hF0 + 8'(i), i == 0, i == 3, 1'b0));
        drive();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pq[0].delete();
        drive();
        @(negedge clk);
        chk("t6_grant", 32'(grant), 32'(0));
        chk("t6_valid", 32'(out_valid), 32'(0));
        chk("t6_sop", 32'(out_sop), 32'(0));
        chk("t6_eop", 32'(out_eop), 32'(0));
        chk("t6_data", 32'(out_data), 32'(0));
        chk("t6_ready", 32'(in_ready), 32'(0));
        chk("t6_drop", 32'(drop_count), 32'(0));
        sync();
        clr_logs();
        pq[0].push_back(mk(8'h71, 1'b1, 1'b0, 1'b0));
        pq[0].push_back(mk(8'h72, 1'b0, 1'b1, 1'b0));
        drive();
        repeat (8) step();
        chk("t6_regrant", 32'(lg_grant[1]), 32'(4'b0001));
        chk("t6_count", 32'(oq.size()), 32'(2));
        if (oq.size() == 2) begin
            chk("t6_b0", 32'(oq[0]), 32'(mk(8'h71, 1'b1, 1'b0, 1'b0)));
            chk("t6_b1", 32'(oq[1]), 32'(mk(8'h72, 1'b0, 1'b1, 1'b0)));
        end

        // Randomized traffic against the packet-level model
        do_reset();
        clr_logs();
        bubbles = 1'b1;
        tot = 0;
        norph = 0;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                int len;
                if ($urandom_range(0, 4) == 0) begin
                    int no;
                    no = int'($urandom_range(1, 2));
                    for (int j = 0; j < no; j++)
                        pq[p].push_back(mk(8'($urandom), 1'b0, 1'b0, 1'b1));
                    norph += no;
                end
                len = int'($urandom_range(1, 12));
                for (int j = 0; j < len; j++) begin
                    b = mk(8'($urandom), j == 0, j == len - 1, 1'b0);
                    pq[p].push_back(b);
                    expb[p].push_back(b);
                end
                tot += len;
            end
        end
        drive();
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (pq[0].size() == 0 && pq[1].size() == 0 &&
                pq[2].size() == 0 && pq[3].size() == 0 &&
                oq.size() >= tot)
                break;
        end
        out_ready = 1'b1;
        repeat (6) step();
        bubbles = 1'b0;
        chk("rnd_total", 32'(oq.size()), 32'(tot));
        chk("rnd_drop", 32'(drop_count), 32'(norph));
        segs();
        last = NP - 1;
        exps.delete();
        for (int s = 0; s < seg_q.size(); s++) begin
            if (segk_q[s] > 0) begin
                e = rr_pick(last, lg_req[segk_q[s]-1]);
                chk("rnd_rr", 32'(seg_q[s]),
                    (e < 0) ? 32'(0) : (32'(1) << e));
                if (s > 0)
                    chk("rnd_gap", 32'(zr_q[s] >= GAP + 1), 32'(1));
                if (e >= 0) begin
                    last = e;
                    while (expb[e].size() > 0) begin
                        b = expb[e].pop_front();
                        exps.push_back(b);
                        if (b.eop) break;
                    end
                end
            end
        end
        chk("rnd_model_len", 32'(exps.size()), 32'(tot));
        for (int i = 0; i < oq.size() && i < exps.size(); i++)
            chk("rnd_beat", 32'(oq[i]), 32'(exps[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
